ram_writer: RTL and testbench
=============================

RAM_WRITER -- requirements
Module: ram_writer

Interface
REQ-001 Parameter NBITS_ADDR, default 2, SHALL set address width (2^NBITS_ADDR words).
REQ-002 Parameter NBITS_DATA, default 4, SHALL set word width.
REQ-003 clk_2  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be synchronous and active-high.
REQ-005 wr_req  input  1  SHALL request a single-word write; sampled only in IDLE.
REQ-006 wr_addr  input  NBITS_ADDR  SHALL give the write address, captured with wr_req.
REQ-007 wr_data  input  NBITS_DATA  SHALL give the write word, captured with wr_req.
REQ-008 fill_req  input  1  SHALL request a fill of all words with the fixed pattern; sampled only in IDLE.
REQ-009 rd_addr  input  NBITS_ADDR  SHALL give the read address.
REQ-010 rd_data  output  NBITS_DATA  SHALL give the registered word at rd_addr.
REQ-011 busy  output  1  SHALL be high in every state except IDLE.
REQ-012 done  output  1  SHALL pulse high for exactly one cycle when a write or fill completes.
REQ-013 wr_count  output  4  SHALL count completed word writes, saturating at 15.

Function
REQ-014 FSM states SHALL be IDLE, WRITE, FILL, DONE.
REQ-015 IDLE: if fill_req=1, go to FILL with fill pointer 0; else if wr_req=1, capture wr_addr/wr_data, go to WRITE; else stay.
REQ-016 fill_req and wr_req both high in IDLE: fill SHALL win; the write request SHALL be dropped.
REQ-017 WRITE: store the captured word at the captured address in one cycle, increment wr_count, go to DONE.
REQ-018 FILL: each cycle, store pattern[ptr] at address ptr, increment wr_count and ptr; after the last address (ptr = 2^NBITS_ADDR-1), go to DONE.
REQ-019 Fill pattern for defaults: addr 0->4'b0011, 1->4'b0110, 2->4'b1001, 3->4'b1100.
REQ-020 DONE: assert done for one cycle, return to IDLE.
REQ-021 wr_req/fill_req while busy=1 SHALL be ignored; no queuing.
REQ-022 Single write: busy high 2 cycles (WRITE, DONE); fill: busy high 2^NBITS_ADDR+1 cycles.
REQ-023 rd_data SHALL equal mem[rd_addr] one cycle after rd_addr is applied (1-cycle latency), in every state.
REQ-024 Read and write to the same address in the same cycle: rd_data SHALL return the old word; the new word is visible the following cycle.
REQ-025 wr_count at 15 SHALL hold at 15 on further writes.
REQ-026 Fill pointer SHALL not wrap within one fill; the pointer is reset to 0 on FILL entry.

Reset
REQ-027 reset=1 at a clock edge SHALL force state IDLE, busy=0, done=0, wr_count=0, rd_data=0, fill pointer 0, and all memory words 0.
REQ-028 reset asserted mid-WRITE or mid-FILL SHALL abort the operation; no done pulse; memory cleared per REQ-027.
REQ-029 reset SHALL take priority over all requests in the same cycle.

Structure
REQ-030 Package ram_writer_pkg SHALL hold NBITS_ADDR/NBITS_DATA defaults, the state enum type, and the fill-pattern constant array.
REQ-031 Storage SHALL be a sub-module ram_sp (single write port, registered read port, synchronous clear); ram_writer holds the FSM, capture registers, pointer and counter.
REQ-032 No latches; the memory SHALL use only clk_2.

Verification
REQ-033 Reset, then wr_req=1, addr=2, data=4'hA for one cycle -> busy=1 for 2 cycles, done pulse on 2nd cycle, wr_count=1; rd_addr=2 -> rd_data=4'hA one cycle later.
REQ-034 fill_req=1 from IDLE -> busy 5 cycles, one done pulse, wr_count=4; reading addr 0..3 returns 3,6,9,C.
REQ-035 fill_req and wr_req (addr 1, data F) together -> fill performed, addr 1 reads 6, wr_count=4.
REQ-036 wr_req pulsed during fill cycle 2 -> ignored; contents equal the fill pattern; single done pulse.
REQ-037 reset asserted in fill cycle 3 -> no done, wr_count=0, all words read 0, state IDLE next cycle.
REQ-038 Four fills back-to-back -> wr_count saturates at 15; simultaneous read/write same address returns old data, then new.

Source files
------------

// File: rtl/ram_writer_pkg.sv
// ----------------------------------------------------------------------------
// ram_writer_pkg : shared widths, FSM state type and fill pattern for ram_writer
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ram_writer_pkg;

  localparam int NBITS_ADDR_DEF = 2;
  localparam int NBITS_DATA_DEF = 4;
  localparam int WR_COUNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [NBITS_DATA_DEF-1:0] FILL_PATTERN [2**NBITS_ADDR_DEF] =
    '{4'h3, 4'h6, 4'h9, 4'hC};

  // Generalisation of FILL_PATTERN for non-default geometries: 3*(addr+1).
  function automatic logic [31:0] fill_word(input logic [31:0] ptr);
    return 32'd3 * (ptr + 32'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_writer_if.sv
// ----------------------------------------------------------------------------
// ram_writer_if : request, read and status signals of ram_writer
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface ram_writer_if #(
  parameter int NBITS_ADDR = 2,
  parameter int NBITS_DATA = 4
) ();

  logic                  wr_req;
  logic [NBITS_ADDR-1:0] wr_addr;
  logic [NBITS_DATA-1:0] wr_data;
  logic                  fill_req;
  logic [NBITS_ADDR-1:0] rd_addr;
  logic [NBITS_DATA-1:0] rd_data;
  logic                  busy;
  logic                  done;
  logic [3:0]            wr_count;

  modport master (
    output wr_req, wr_addr, wr_data, fill_req, rd_addr,
    input  rd_data, busy, done, wr_count
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, fill_req, rd_addr,
    output rd_data, busy, done, wr_count
  );

endinterface

`default_nettype wire

// File: rtl/ram_sp.sv
// ----------------------------------------------------------------------------
// ram_sp : single write port RAM with registered read and synchronous clear
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ram_sp #(
  parameter int NBITS_ADDR = 2,
  parameter int NBITS_DATA = 4
) (
  input  wire logic                  clk_2,
  input  wire logic                  clr_i,
  input  wire logic                  we_i,
  input  wire logic [NBITS_ADDR-1:0] waddr_i,
  input  wire logic [NBITS_DATA-1:0] wdata_i,
  input  wire logic [NBITS_ADDR-1:0] raddr_i,
  output logic      [NBITS_DATA-1:0] rdata_o
);

  localparam int DEPTH = 2**NBITS_ADDR;

  logic [NBITS_DATA-1:0] mem_q [DEPTH];
  logic [NBITS_DATA-1:0] rdata_q;

  // Read samples the array before this edge's write lands: same-address
  // read/write returns the old word.
  always_ff @(posedge clk_2) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/ram_writer.sv
// ----------------------------------------------------------------------------
// ram_writer : single-word write / pattern fill controller around ram_sp
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ram_writer
  import ram_writer_pkg::*;
#(
  parameter int NBITS_ADDR = NBITS_ADDR_DEF,
  parameter int NBITS_DATA = NBITS_DATA_DEF
) (
  input wire logic clk_2,
  input wire logic reset,
  ram_writer_if.slave bus
);

  localparam logic [NBITS_ADDR-1:0] LAST_ADDR = '1;
  localparam logic [WR_COUNT_W-1:0] CNT_MAX   = '1;

  state_e                  state_q, state_d;
  logic [NBITS_ADDR-1:0]   addr_q,  addr_d;
  logic [NBITS_DATA-1:0]   data_q,  data_d;
  logic [NBITS_ADDR-1:0]   ptr_q,   ptr_d;
  logic [WR_COUNT_W-1:0]   cnt_q,   cnt_d;

  logic                    we_w;
  logic [NBITS_ADDR-1:0]   waddr_w;
  logic [NBITS_DATA-1:0]   wdata_w;
  logic [NBITS_DATA-1:0]   fill_word_w;
  logic [WR_COUNT_W-1:0]   cnt_inc_w;

  generate
    if (NBITS_ADDR == NBITS_ADDR_DEF && NBITS_DATA == NBITS_DATA_DEF) begin : g_table_pattern
      assign fill_word_w = FILL_PATTERN[ptr_q];
    end else begin : g_arith_pattern
      assign fill_word_w = NBITS_DATA'(fill_word(32'(ptr_q)));
    end
  endgenerate

  assign cnt_inc_w = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    we_w    = 1'b0;
    waddr_w = addr_q;
    wdata_w = data_q;
    case (state_q)
      ST_IDLE: begin
        // Fill has priority; a simultaneous write request is dropped.
        if (bus.fill_req) begin
          ptr_d   = '0;
          state_d = ST_FILL;
        end else if (bus.wr_req) begin
          addr_d  = bus.wr_addr;
          data_d  = bus.wr_data;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        we_w    = 1'b1;
        cnt_d   = cnt_inc_w;
        state_d = ST_DONE;
      end
      ST_FILL: begin
        we_w    = 1'b1;
        waddr_w = ptr_q;
        wdata_w = fill_word_w;
        cnt_d   = cnt_inc_w;
        if (ptr_q == LAST_ADDR) begin
          state_d = ST_DONE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.wr_count = cnt_q;

  ram_sp #(
    .NBITS_ADDR (NBITS_ADDR),
    .NBITS_DATA (NBITS_DATA)
  ) u_ram (
    .clk_2   (clk_2),
    .clr_i   (reset),
    .we_i    (we_w),
    .waddr_i (waddr_w),
    .wdata_i (wdata_w),
    .raddr_i (bus.rd_addr),
    .rdata_o (bus.rd_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_ram_writer.sv
// ----------------------------------------------------------------------------
// tb_ram_writer : directed and randomized checks of ram_writer against a model
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ram_writer;

  localparam int AW = 2;
  localparam int DW = 4;
  localparam int N  = 2**AW;

  logic clk_2 = 1'b0;
  logic reset;

  ram_writer_if #(.NBITS_ADDR(AW), .NBITS_DATA(DW)) bus ();

  ram_writer #(.NBITS_ADDR(AW), .NBITS_DATA(DW)) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_2 = ~clk_2;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a request becomes a queue of word writes, one
  // retired per cycle, followed by a single completion cycle.
  typedef struct {
    int a;
    int d;
  } wr_t;

  logic [DW-1:0] m_mem [N];
  int            m_cnt;
  bit            m_busy;
  bit            m_done;
  logic [DW-1:0] m_rd;
  wr_t           m_ops [$];
  wr_t           m_w;

  function automatic int pat(input int a);
    return (3 * (a + 1)) & 15;
  endfunction

  always @(posedge clk_2) begin
    if (reset) begin
      for (int i = 0; i < N; i++) m_mem[i] = '0;
      m_cnt  = 0;
      m_busy = 0;
      m_done = 0;
      m_rd   = '0;
      m_ops.delete();
    end else begin
      m_rd = m_mem[bus.rd_addr];
      if (!m_busy) begin
        if (bus.fill_req) begin
          for (int i = 0; i < N; i++) m_ops.push_back('{i, pat(i)});
          m_busy = 1;
        end else if (bus.wr_req) begin
          m_ops.push_back('{int'(bus.wr_addr), int'(bus.wr_data)});
          m_busy = 1;
        end
      end else if (m_done) begin
        m_busy = 0;
        m_done = 0;
      end else begin
        m_w = m_ops.pop_front();
        m_mem[m_w.a] = DW'(m_w.d);
        if (m_cnt < 15) m_cnt++;
        if (m_ops.size() == 0) m_done = 1;
      end
    end
  end

  always @(negedge clk_2) begin
    if (chk_en) begin
      check("model_busy",     32'(bus.busy),     32'(m_busy));
      check("model_done",     32'(bus.done),     32'(m_done));
      check("model_wr_count", 32'(bus.wr_count), 32'(m_cnt));
      check("model_rd_data",  32'(bus.rd_data),  32'(m_rd));
    end
  end

  logic [3:0] lit_pat [N] = '{4'h3, 4'h6, 4'h9, 4'hC};

  task automatic cyc();
    @(posedge clk_2);
    #1;
  endtask

  task automatic idle_in();
    bus.wr_req   = 1'b0;
    bus.fill_req = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Called just after the request edge; counts busy and done cycles.
  task automatic run_op(output int nb, output int nd);
    nb = 0;
    nd = 0;
    for (int i = 0; i < 20 && bus.busy; i++) begin
      nb++;
      if (bus.done) nd++;
      cyc();
    end
    check("op_timeout_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic read_chk(input string nm, input int a, input logic [3:0] exp);
    bus.rd_addr = AW'(a);
    cyc();
    check(nm, 32'(bus.rd_data), 32'(exp));
  endtask

  task automatic start_fill();
    bus.fill_req = 1'b1;
    cyc();
    idle_in();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time %0t exceeded bound", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nd;
    reset        = 1'b1;
    bus.wr_req   = 1'b0;
    bus.fill_req = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_addr  = '0;
    cyc();
    cyc();
    chk_en = 1'b1;
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_done",     32'(bus.done),     32'd0);
    check("rst_wr_count", 32'(bus.wr_count), 32'd0);
    check("rst_rd_data",  32'(bus.rd_data),  32'd0);
    reset = 1'b0;

    // Single write of A to address 2.
    bus.wr_req = 1'b1; bus.wr_addr = 2'd2; bus.wr_data = 4'hA;
    cyc();
    idle_in();
    check("wr_busy_c1", 32'(bus.busy), 32'd1);
    check("wr_done_c1", 32'(bus.done), 32'd0);
    cyc();
    check("wr_busy_c2", 32'(bus.busy), 32'd1);
    check("wr_done_c2", 32'(bus.done), 32'd1);
    bus.rd_addr = 2'd2;
    cyc();
    check("wr_busy_end",  32'(bus.busy),     32'd0);
    check("wr_count_1",   32'(bus.wr_count), 32'd1);
    check("wr_read_back", 32'(bus.rd_data),  32'hA);

    // Plain fill.
    do_reset();
    start_fill();
    run_op(nb, nd);
    check("fill_busy_cycles", 32'(nb), 32'd5);
    check("fill_done_pulses", 32'(nd), 32'd1);
    check("fill_wr_count",    32'(bus.wr_count), 32'd4);
    for (int i = 0; i < N; i++) read_chk("fill_pattern", i, lit_pat[i]);

    // Fill and write requested together: fill wins.
    do_reset();
    bus.fill_req = 1'b1; bus.wr_req = 1'b1; bus.wr_addr = 2'd1; bus.wr_data = 4'hF;
    cyc();
    idle_in();
    run_op(nb, nd);
    read_chk("fill_wins_addr1", 1, 4'h6);
    check("fill_wins_count", 32'(bus.wr_count), 32'd4);

    // Write request during fill cycle 2 is ignored.
    do_reset();
    start_fill();
    cyc();
    bus.wr_req = 1'b1; bus.wr_addr = 2'd0; bus.wr_data = 4'h0;
    cyc();
    idle_in();
    run_op(nb, nd);
    check("busy_wr_ignored_done", 32'(nd), 32'd1);
    check("busy_wr_remaining",    32'(nb), 32'd3);
    for (int i = 0; i < N; i++) read_chk("busy_wr_pattern", i, lit_pat[i]);

    // Reset in fill cycle 3 aborts.
    do_reset();
    start_fill();
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("abort_busy",  32'(bus.busy),     32'd0);
    check("abort_done",  32'(bus.done),     32'd0);
    check("abort_count", 32'(bus.wr_count), 32'd0);
    for (int i = 0; i < N; i++) begin
      read_chk("abort_mem_zero", i, 4'h0);
      check("abort_no_done", 32'(bus.done), 32'd0);
    end

    // Saturation and same-address read/write.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      start_fill();
      run_op(nb, nd);
    end
    check("sat_count", 32'(bus.wr_count), 32'd15);
    bus.rd_addr = 2'd3;
    bus.wr_req = 1'b1; bus.wr_addr = 2'd3; bus.wr_data = 4'h5;
    cyc();
    idle_in();
    cyc();
    check("rw_same_old", 32'(bus.rd_data), 32'hC);
    cyc();
    check("rw_same_new",   32'(bus.rd_data),  32'h5);
    check("sat_count_hold", 32'(bus.wr_count), 32'd15);

    // Randomized traffic, checked every cycle by the model compare.
    for (int c = 0; c < 800; c++) begin
      reset        = ($urandom_range(0, 99) == 0);
      bus.fill_req = ($urandom_range(0, 9) == 0);
      bus.wr_req   = ($urandom_range(0, 2) == 0);
      bus.wr_addr  = AW'($urandom);
      bus.wr_data  = DW'($urandom);
      bus.rd_addr  = AW'($urandom);
      cyc();
    end
    reset = 1'b0;
    idle_in();
    repeat (8) cyc();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
